// File: rtl/sseg_scan_capture.sv
// Receive side of the 7-segment display multiplexer: samples the active-low an/seg bus and
// rebuilds the four digit patterns, with frame, error and stale-scan reporting.
module sseg_scan_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] seg,
    input  logic       err_clr,
    output logic [7:0] dig0,
    output logic [7:0] dig1,
    output logic [7:0] dig2,
    output logic [7:0] dig3,
    output logic       frame_valid,
    output logic [7:0] frame_cnt,
    output logic       err,
    output logic       stale
);

    localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [23:0] WD_LAST     = 24'(TIMEOUT - 1);

    logic [3:0]  an_q;
    logic [7:0]  seg_q;
    logic [11:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  seen_q, seen_upd;
    logic [23:0] wd_q;

    logic [3:0] an_sel;
    logic       legal, illegal, same, capture, frame_done, expire;

    always_comb begin
        an_sel     = ~an_q;
        legal      = (an_sel != 4'd0) && ((an_sel & (an_sel - 4'd1)) == 4'd0);
        illegal    = (an_sel != 4'd0) && !legal;
        same       = ({an_q, seg_q} == prev_q);
        capture    = legal && same && (cnt_q == SETTLE_LAST);
        seen_upd   = seen_q | (capture ? an_sel : 4'd0);
        frame_done = capture && (seen_upd == 4'hF);
        // A capture in the expiry cycle restarts the watchdog instead.
        expire     = !capture && (wd_q == WD_LAST);

        cnt_d = 8'd0;
        if (legal && same) begin
            cnt_d = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + 8'd1;
        end else if (legal) begin
            cnt_d = 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q   <= 4'hF;
            seg_q  <= 8'hFF;
            prev_q <= 12'hFFF;
            cnt_q  <= 8'd0;
        end else begin
            an_q   <= an;
            seg_q  <= seg;
            prev_q <= {an_q, seg_q};
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig0 <= 8'hFF;
            dig1 <= 8'hFF;
            dig2 <= 8'hFF;
            dig3 <= 8'hFF;
        end else if (capture) begin
            if (an_sel[0]) dig0 <= seg_q;
            if (an_sel[1]) dig1 <= seg_q;
            if (an_sel[2]) dig2 <= seg_q;
            if (an_sel[3]) dig3 <= seg_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q      <= 4'd0;
            frame_valid <= 1'b0;
            frame_cnt   <= 8'd0;
            wd_q        <= 24'd0;
            stale       <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) frame_cnt <= frame_cnt + 8'd1;

            if (frame_done || expire) seen_q <= 4'd0;
            else                      seen_q <= seen_upd;

            if (capture)               wd_q <= 24'd0;
            else if (wd_q != 24'hFFFFFF) wd_q <= wd_q + 24'd1;

            if (expire)           stale <= 1'b1;
            else if (frame_valid) stale <= 1'b0;

            if (illegal)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture with SETTLE=4, TIMEOUT=64.
module tb_sseg_scan_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [7:0] seg;
    logic       err_clr;
    logic [7:0] dig0, dig1, dig2, dig3;
    logic       frame_valid;
    logic [7:0] frame_cnt;
    logic       err, stale;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int p0;

    logic [7:0] pat [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

    sseg_scan_capture #(.SETTLE(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .seg        (seg),
        .err_clr    (err_clr),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .frame_valid(frame_valid),
        .frame_cnt  (frame_cnt),
        .err        (err),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && frame_valid) n_pulse <= n_pulse + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hold (a, s) for n sampling edges; returns on the negedge after the (n-1)th edge.
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drive_digit(input int i, input int n);
        logic [3:0] one;
        one = 4'b0001 << i;
        drive(~one, pat[i], n);
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < 4; i++) drive_digit(i, n);
    endtask

    initial begin
        reset = 1'b1; an = 4'hF; seg = 8'hFF; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("init_dig0", dig0, 8'hFF);
        check_eq("init_fcnt", frame_cnt, 0);

        // Clean scan: one pulse per 32-cycle frame
        p0 = n_pulse;
        for (int f = 1; f <= 3; f++) begin
            scan(8);
            check_eq("scan_pulses", n_pulse - p0, f);
            check_eq("scan_fcnt", frame_cnt, f);
        end
        check_eq("scan_dig", {dig0, dig1, dig2, dig3}, 32'hC0F9A4B0);

        // Glitch: 3-cycle dwell rejected, 4-cycle dwell captured 4 edges later
        p0 = n_pulse;
        drive_digit(0, 8);
        drive(4'b1101, 8'h00, 3);
        drive_digit(2, 8);
        check_eq("glitch3_dig1", dig1, 8'hF9);
        check_eq("glitch3_pulses", n_pulse - p0, 0);
        @(negedge clk); an = 4'b1101; seg = 8'h00;
        repeat (4) @(negedge clk);
        check_eq("glitch4_early", dig1, 8'hF9);
        @(negedge clk);
        check_eq("glitch4_dig1", dig1, 8'h00);
        check_eq("glitch4_dig3", dig3, 8'hB0);

        // Illegal anode code
        drive(4'b1100, 8'h55, 1);
        drive(4'hF, 8'hFF, 1);
        @(negedge clk);
        check_eq("illegal_err", err, 1);
        repeat (3) @(negedge clk);
        check_eq("illegal_hold", err, 1);
        check_eq("illegal_nocap", {dig0, dig1, dig2, dig3}, 32'hC000A4B0);
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check_eq("err_clr", err, 0);
        an = 4'b0000;
        @(negedge clk); an = 4'hF; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check_eq("err_set_wins", err, 1);
        @(negedge clk);
        check_eq("err_set_hold", err, 1);

        // Blanking timeout: partial frame (0,1) discarded
        p0 = n_pulse;
        drive_digit(0, 8);
        drive_digit(1, 8);
        drive(4'hF, 8'hFF, 50);
        check_eq("stale_early", stale, 0);
        drive(4'hF, 8'hFF, 20);
        check_eq("stale_set", stale, 1);
        check_eq("stale_dig", {dig0, dig1}, 16'hC0F9);
        drive_digit(2, 8);
        drive_digit(3, 8);
        check_eq("stale_seen_clr", n_pulse - p0, 0);
        drive_digit(0, 8);
        drive_digit(1, 8);
        check_eq("stale_frame", n_pulse - p0, 1);
        check_eq("stale_clr", stale, 0);
        check_eq("stale_fcnt", frame_cnt, 4);

        // Asynchronous reset mid-frame
        drive_digit(2, 3);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_dig", {dig0, dig1, dig2, dig3}, 32'hFFFFFFFF);
        check_eq("rst_fcnt", frame_cnt, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_stale", stale, 0);
        check_eq("rst_fv", frame_valid, 0);
        @(negedge clk); an = 4'hF; seg = 8'hFF;
        @(negedge clk); reset = 1'b0;

        // Wrap of frame_cnt
        p0 = n_pulse;
        for (int f = 0; f < 255; f++) scan(5);
        drive(4'hF, 8'hFF, 3);
        check_eq("wrap_255", frame_cnt, 255);
        scan(5);
        drive(4'hF, 8'hFF, 3);
        check_eq("wrap_0", frame_cnt, 0);
        check_eq("wrap_pulses", n_pulse - p0, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
